// File: rtl/klotski_scrambler.sv
// Builds a random, solvable 4x4 sliding-puzzle board by walking the blank from the
// solved position with LFSR-chosen legal moves, then pulses o_start for the solver.
module klotski_scrambler #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_moves,
  output logic [3:0][3:0][3:0]  o_klotski,
  output logic                  o_start,
  output logic                  o_busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StMove, StDone} state_e;

  localparam logic [15:0] SeedEff  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [63:0] Solved   = 64'h123456789ABCDEF0;
  localparam logic [15:0] LfsrMask = 16'hB400;

  state_e               state_q, state_d;
  logic [3:0][3:0][3:0] board_q, board_d;
  logic [1:0]           row_q, row_d, col_q, col_d;
  logic [1:0]           prev_q, prev_d;
  logic                 prev_vld_q, prev_vld_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [15:0]          lfsr_q, lfsr_d;

  logic [1:0] dir, cand, nrow, ncol;
  logic       found, on_board, legal;

  // First of d, d+1, d+2, d+3 that stays on the board and does not undo the last move.
  always_comb begin
    dir      = 2'd0;
    found    = 1'b0;
    cand     = 2'd0;
    on_board = 1'b0;
    legal    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = lfsr_q[1:0] + 2'(k);
      unique case (cand)
        2'd0:    on_board = (row_q != 2'd0);
        2'd1:    on_board = (row_q != 2'd3);
        2'd2:    on_board = (col_q != 2'd0);
        default: on_board = (col_q != 2'd3);
      endcase
      legal = on_board && !(prev_vld_q && (cand == (prev_q ^ 2'd1)));
      if (legal && !found) begin
        dir   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    nrow = row_q;
    ncol = col_q;
    unique case (dir)
      2'd0:    nrow = row_q - 2'd1;
      2'd1:    nrow = row_q + 2'd1;
      2'd2:    ncol = col_q - 2'd1;
      default: ncol = col_q + 2'd1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    row_d      = row_q;
    col_d      = col_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          cnt_d   = i_moves;
          state_d = StLoad;
        end
      end
      StLoad: begin
        board_d    = Solved;
        row_d      = 2'd3;
        col_d      = 2'd3;
        prev_vld_d = 1'b0;
        state_d    = (cnt_q != 8'd0) ? StMove : StDone;
      end
      StMove: begin
        // Row r / column c lives at board[3-r][3-c], i.e. index ~r / ~c.
        board_d[~row_q][~col_q] = board_q[~nrow][~ncol];
        board_d[~nrow][~ncol]   = 4'd0;
        row_d      = nrow;
        col_d      = ncol;
        prev_d     = dir;
        prev_vld_d = 1'b1;
        cnt_d      = cnt_q - 8'd1;
        lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
        if (cnt_q == 8'd1) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      board_q    <= Solved;
      row_q      <= 2'd3;
      col_q      <= 2'd3;
      prev_q     <= 2'd0;
      prev_vld_q <= 1'b0;
      cnt_q      <= 8'd0;
      lfsr_q     <= SeedEff;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      row_q      <= row_d;
      col_q      <= col_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign o_klotski = board_q;
  assign o_start   = (state_q == StDone);
  assign o_busy    = (state_q == StLoad) || (state_q == StMove);

endmodule

// File: tb/tb_klotski_scrambler.sv
// Directed bench for klotski_scrambler: hand-computed vectors, an independent
// reference scrambler, board validity checks and reset/start corner cases.
module tb_klotski_scrambler;

  localparam logic [63:0] Solved = 64'h123456789ABCDEF0;

  logic                 clk = 1'b0;
  logic                 rst, start;
  logic [7:0]           moves;
  logic [3:0][3:0][3:0] k_a, k_b;
  logic                 st_a, st_b, busy_a, busy_b;

  always #5 clk = ~clk;

  klotski_scrambler #(.SEED(16'hACE1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_moves(moves),
    .o_klotski(k_a), .o_start(st_a), .o_busy(busy_a)
  );

  klotski_scrambler #(.SEED(16'h0000)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_moves(moves),
    .o_klotski(k_b), .o_start(st_b), .o_busy(busy_b)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] m_lfsr_a, m_lfsr_b;

  typedef struct {
    int          n;
    logic [63:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    if (l[0]) return (l >> 1) ^ 16'hB400;
    return l >> 1;
  endfunction

  // Reference scrambler on a flat row-major tile array.
  task automatic model_scramble(input int n, input logic [15:0] l_in,
                                output logic [63:0] brd, output logic [15:0] l_out);
    int t[16];
    int b, prev, d, c, pick, r, col, nb;
    bit ok;
    logic [15:0] l;
    l = l_in; b = 15; prev = -1;
    for (int i = 0; i < 16; i++) t[i] = (i + 1) % 16;
    for (int m = 0; m < n; m++) begin
      d = int'(l[1:0]); pick = -1; r = b / 4; col = b % 4;
      for (int k = 0; k < 4; k++) begin
        c  = (d + k) % 4;
        ok = (c == 0 && r > 0) || (c == 1 && r < 3) || (c == 2 && col > 0) || (c == 3 && col < 3);
        if (prev >= 0 && c == (prev ^ 1)) ok = 0;
        if (ok && pick < 0) pick = c;
      end
      nb = b + ((pick == 0) ? -4 : (pick == 1) ? 4 : (pick == 2) ? -1 : 1);
      t[b] = t[nb]; t[nb] = 0; b = nb; prev = pick;
      l = lfsr_next(l);
    end
    for (int i = 0; i < 16; i++) brd[63-4*i -: 4] = 4'(t[i]);
    l_out = l;
  endtask

  function automatic int blank_pos(input logic [63:0] v);
    for (int i = 0; i < 16; i++) if (v[63-4*i -: 4] == 4'd0) return i;
    return -1;
  endfunction

  function automatic bit board_ok(input logic [63:0] v);
    bit seen[16];
    int inv, bp;
    logic [3:0] a, b;
    for (int i = 0; i < 16; i++) seen[i] = 0;
    for (int i = 0; i < 16; i++) begin
      a = v[63-4*i -: 4];
      if (seen[a]) return 0;
      seen[a] = 1;
    end
    inv = 0;
    for (int i = 0; i < 16; i++)
      for (int j = i + 1; j < 16; j++) begin
        a = v[63-4*i -: 4]; b = v[63-4*j -: 4];
        if (a != 0 && b != 0 && a > b) inv++;
      end
    bp = blank_pos(v);
    return ((inv + (3 - bp / 4)) % 2) == 0;
  endfunction

  function automatic bit adjacent(input int p, input int q);
    int dr, dc;
    dr = p / 4 - q / 4; dc = p % 4 - q % 4;
    if (dr < 0) dr = -dr;
    if (dc < 0) dc = -dc;
    return (dr + dc) == 1;
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; start = 1'b0; moves = 8'd0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    m_lfsr_a = 16'hACE1;
    m_lfsr_b = 16'h0001;
  endtask

  // Issues one start and samples every negedge until o_start (bounded).
  task automatic run_scramble(input int n, input int poke_at, output int lat,
                              output int busy_cnt, output bit walk_ok);
    int p, p1, p2;
    walk_ok = 1; p1 = -1; p2 = -1;
    @(negedge clk); moves = 8'(n); start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 1; busy_cnt = int'(busy_a);
    while (!st_a && lat < n + 20) begin
      if (lat == poke_at) begin start = 1'b1; moves = 8'd3; end
      else start = 1'b0;
      @(negedge clk); lat++; busy_cnt += int'(busy_a);
      p = blank_pos(k_a);
      if (lat == 2) p1 = p;
      else if (lat > 2) begin
        if (!adjacent(p, p1) || p == p2) walk_ok = 0;
        p2 = p1; p1 = p;
      end
    end
    start = 1'b0;
    check("start_b_with_a", st_b, 1'b1);
  endtask

  task automatic pulse_gone();
    @(negedge clk);
    check("start_pulse_width", st_a, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, busy_cnt, npulse;
    bit walk_ok;
    int gold_n[3];
    logic [63:0] exp_a, exp_b;

    vecs[0] = '{n: 0, exp: 64'h123456789ABCDEF0, lat: 2};
    vecs[1] = '{n: 1, exp: 64'h123456789ABCDE0F, lat: 3};
    vecs[2] = '{n: 2, exp: 64'h123456789A0CDEBF, lat: 4};
    vecs[3] = '{n: 3, exp: 64'h123456089A7CDEBF, lat: 5};
    gold_n[0] = 2; gold_n[1] = 7; gold_n[2] = 64;
    rst = 1'b1; start = 1'b0; moves = 8'd0;

    do_reset();
    check("reset_board_a", k_a, Solved);
    check("reset_board_b", k_b, Solved);
    check("reset_busy", busy_a, 1'b0);
    check("reset_start", st_a, 1'b0);
    check("reset_lfsr_a", dut_a.lfsr_q, 16'hACE1);
    check("reset_lfsr_b", dut_b.lfsr_q, 16'h0001);

    // Hand-computed boards from reset; both seeds give the same first three moves.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      run_scramble(vecs[v].n, -1, lat, busy_cnt, walk_ok);
      check($sformatf("vec%0d_board_a", v), k_a, vecs[v].exp);
      check($sformatf("vec%0d_board_b", v), k_b, vecs[v].exp);
      check($sformatf("vec%0d_latency", v), 64'(lat), 64'(vecs[v].lat));
      check($sformatf("vec%0d_busy_cycles", v), 64'(busy_cnt), 64'(vecs[v].n + 1));
      pulse_gone();
    end

    do_reset();
    for (int g = 0; g < 3; g++) begin
      model_scramble(gold_n[g], m_lfsr_a, exp_a, m_lfsr_a);
      model_scramble(gold_n[g], m_lfsr_b, exp_b, m_lfsr_b);
      run_scramble(gold_n[g], -1, lat, busy_cnt, walk_ok);
      check($sformatf("gold%0d_board_a", gold_n[g]), k_a, exp_a);
      check($sformatf("gold%0d_board_b", gold_n[g]), k_b, exp_b);
      check($sformatf("gold%0d_latency", gold_n[g]), 64'(lat), 64'(gold_n[g] + 2));
      pulse_gone();
    end

    for (int r = 0; r < 20; r++) begin
      model_scramble(255, m_lfsr_a, exp_a, m_lfsr_a);
      model_scramble(255, m_lfsr_b, exp_b, m_lfsr_b);
      run_scramble(255, -1, lat, busy_cnt, walk_ok);
      check($sformatf("long%0d_board_a", r), k_a, exp_a);
      check($sformatf("long%0d_board_b", r), k_b, exp_b);
      check($sformatf("long%0d_valid_a", r), 64'(board_ok(k_a)), 64'd1);
      check($sformatf("long%0d_valid_b", r), 64'(board_ok(k_b)), 64'd1);
      check($sformatf("long%0d_no_undo", r), 64'(walk_ok), 64'd1);
      check($sformatf("long%0d_latency", r), 64'(lat), 64'd257);
    end

    // Start/moves poked mid-MOVE must not disturb the running 20-move scramble.
    model_scramble(20, m_lfsr_a, exp_a, m_lfsr_a);
    model_scramble(20, m_lfsr_b, exp_b, m_lfsr_b);
    run_scramble(20, 6, lat, busy_cnt, walk_ok);
    check("poke_board_a", k_a, exp_a);
    check("poke_latency", 64'(lat), 64'd22);
    pulse_gone();
    repeat (3) @(negedge clk);
    check("poke_idle_after", busy_a, 1'b0);

    // Held start with zero moves: LOAD, DONE, IDLE repeating.
    @(negedge clk); moves = 8'd0; start = 1'b1;
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      npulse += int'(st_a);
    end
    start = 1'b0;
    check("held_start_pulses", 64'(npulse), 64'd3);
    repeat (3) @(negedge clk);

    // Reset while the 10th move of a 50-move scramble is in progress.
    do_reset();
    @(negedge clk); moves = 8'd50; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_before", busy_a, 1'b1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_board", k_a, Solved);
    check("abort_busy", busy_a, 1'b0);
    check("abort_lfsr_a", dut_a.lfsr_q, 16'hACE1);
    check("abort_lfsr_b", dut_b.lfsr_q, 16'h0001);
    npulse = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      npulse += int'(st_a) + int'(busy_a);
    end
    check("abort_no_start", 64'(npulse), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/klotski_scrambler.md
# klotski_scrambler

Generates a random, guaranteed-solvable 4x4 sliding-puzzle board and hands it to the `Solver` as its start stimulus. It starts from the solved board and applies a programmable number of random legal blank moves, so the result is always reachable. It acts as the initiator side of the solver's `i_klotski`/`i_start` interface: its outputs drive those solver inputs directly.

## Interface
- `SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- `i_clk` in 1: clock; all logic is on the rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: request a new scramble. Sampled only in IDLE; ignored otherwise.
- `i_moves` in 8: number of moves to apply, 0..255. Sampled with `i_start`.
- `o_klotski` out [3:0][3:0][3:0]: the board. Connects to the solver's `i_klotski`.
- `o_start` out 1: one-cycle pulse when the board is final. Connects to the solver's `i_start`.
- `o_busy` out 1: high in LOAD and MOVE.

## Operation
- Board layout: the tile at row r, column c (row 0 = top, column 0 = left) is held in `o_klotski[3-r][3-c]`. Tile 0 is the blank.
- Solved board: `o_klotski` = 64'h123456789ABCDEF0, with the blank at (3,3).
- States: IDLE, LOAD, MOVE, DONE.
- IDLE:
  - `o_busy`=0, `o_start`=0, `o_klotski` holds its last value.
  - `i_start`=1 latches `i_moves` into `cnt` and goes to LOAD.
- LOAD:
  - Writes the solved board.
  - Sets blank position = (3,3) and prev_dir = NONE.
  - Goes to MOVE if `cnt`≠0, else to DONE.
- MOVE: performs one move per cycle.
  - Direction codes (blank displacement): 0 = up (row-1), 1 = down (row+1), 2 = left (col-1), 3 = right (col+1).
  - Candidate d = lfsr[1:0]. Try d, d+1, d+2, d+3 (mod 4), all combinationally in the same cycle.
  - Choose the first candidate that stays on the board and is not the reverse of prev_dir. Reverse pairs are up/down and left/right.
  - A legal choice always exists.
  - Swap the blank with the neighbouring tile, update the blank position and prev_dir, and decrement `cnt`.
  - Go to DONE when `cnt` reaches 0 after the move.
- LFSR: 16-bit Galois, polynomial mask 16'hB400, right-shifting. Each step: lsb = l[0]; l = l>>1; if lsb, l ^= 16'hB400.
  - Steps only in MOVE cycles, using its value before the step.
  - Never re-seeded by `i_start`, so successive scrambles differ.
  - Reloaded with `SEED` only by `i_rst`.
- DONE: `o_start`=1 for exactly this cycle, then return to IDLE.
- Invariants:
  - `o_klotski` is always a permutation of 0..15.
  - Its permutation parity plus the blank's row distance from row 3 is even (solvable).

## Timing
- Reset values:
  - state IDLE
  - `o_klotski` = 64'h123456789ABCDEF0
  - `o_busy`=0, `o_start`=0
  - lfsr = `SEED` (or 16'h0001 if `SEED` is 0)
  - blank position (3,3)
- Cycle numbering, with `i_start` sampled at edge 0:
  - LOAD at edge 1.
  - MOVE edges 2..N+1.
  - DONE, with `o_start` high, during the cycle after edge N+1.
- Latency from the `i_start` edge to `o_start` high is N+2 cycles; N=0 gives 2.
- `o_klotski` is stable from DONE until the next LOAD. The solver may sample it on `o_start`.
- `i_start` held high continuously restarts on the first IDLE cycle after DONE.
- `i_rst` wins over every other input in any state. A reset mid-MOVE aborts the scramble without emitting `o_start`, and all outputs take their reset values on the next edge.
- `i_moves` changing during LOAD/MOVE has no effect.

## Test plan
- **Zero moves:** reset, `i_start` with `i_moves`=0 → `o_start` 2 cycles later, `o_klotski`=64'h123456789ABCDEF0, `o_busy` high for 1 cycle.
- **One move:** `i_moves`=1 → `o_klotski` is 64'h123456789AB0DEFC or 64'h123456789ABCDE0F; latency 3 cycles.
- **Long scramble:** `i_moves`=255, repeated 20 times.
  - Each result is a permutation of 0..15 and passes the solvability parity check.
  - No two consecutive moves undo each other (checked against a model).
  - Latency is 257 cycles.
- **Golden model:** the bench's reference model (same LFSR/rule) matches `o_klotski` bit-exactly for `SEED`=16'hACE1 and `SEED`=0, with `i_moves` in {2, 7, 64}.
- **Reset and ignored start:**
  - `i_rst` asserted at MOVE cycle 10 of a 50-move scramble → no `o_start`; the next cycle shows the solved board, `o_busy`=0, and the LFSR equals `SEED`.
  - `i_start` pulsed during MOVE is ignored, and `cnt` is unaffected.
- **End-to-end:** `klotski_scrambler` drives `Solver` (`i_continue` tied 1) with `i_moves`=8 → the solver's `o_finished` asserts within 10000 cycles.
